// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: assembles big-endian words from a byte stream,
// writes them to IMEM and holds the CPU in reset until the session completes.
// Optional trailing XOR checksum when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rstn,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK = 3'd3,
`endif
    RUN   = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  state_t            next_state;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   written_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       word_q;
  logic [1:0]        byte_cnt_q;
  logic              done_q;
  logic [ADDR_W:0]   clamped_count;
  logic              start_ok;
  logic              accept;
  logic              last_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic       err_q;
  logic       csum_phase_q;
  logic [7:0] xor_q;
  logic [7:0] csum_byte_q;
`endif

  assign clamped_count = (load_count > MAX_WORDS) ? MAX_WORDS : load_count;
  assign start_ok      = load_start && ((state == HOLD) || (state == RUN));
  assign accept        = byte_valid && byte_ready;
  assign last_word     = ((written_q + ONE) == count_q);

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state <= HOLD;
    end else begin
      state <= next_state;
    end
  end

  // Outputs are decoded from the state register alone so no input reaches an output.
  always_comb begin
    next_state = state;
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    busy       = 1'b0;
    cpu_rstn   = 1'b0;
    case (state)
      HOLD: begin
        if (load_start) begin
          next_state = (clamped_count == '0) ? RUN : LOAD;
        end
      end
      LOAD: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (csum_phase_q) begin
            next_state = CHECK;
          end else if (byte_cnt_q == 2'd3) begin
            next_state = WRITE;
          end
`else
          if (byte_cnt_q == 2'd3) begin
            next_state = WRITE;
          end
`endif
        end
      end
      WRITE: begin
        imem_we = 1'b1;
        busy    = 1'b1;
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          next_state = LOAD;
`else
          next_state = RUN;
`endif
        end else begin
          next_state = LOAD;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        busy       = 1'b1;
        next_state = (xor_q == csum_byte_q) ? RUN : HOLD;
      end
`endif
      RUN: begin
        cpu_rstn = 1'b1;
        if (load_start) begin
          next_state = (clamped_count == '0) ? RUN : LOAD;
        end
      end
      default: begin
        next_state = HOLD;
      end
    endcase
  end

  // Session datapath: count latch, word assembly, write index and completion pulse.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      count_q    <= '0;
      written_q  <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      byte_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (next_state == RUN) && ((state != RUN) || load_start);
      if (start_ok) begin
        count_q    <= clamped_count;
        written_q  <= '0;
        addr_q     <= '0;
        byte_cnt_q <= '0;
      end else begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (!csum_phase_q) begin
            word_q     <= {word_q[23:0], byte_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
`else
          word_q     <= {word_q[23:0], byte_data};
          byte_cnt_q <= byte_cnt_q + 2'd1;
`endif
        end
        if (state == WRITE) begin
          written_q <= written_q + ONE;
          // The address stops on the final word so it never wraps past the top of IMEM.
          if (!last_word) begin
            addr_q <= addr_q + 1'b1;
          end
        end
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR of payload bytes, compared against the trailing byte in CHECK.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      err_q        <= 1'b0;
      csum_phase_q <= 1'b0;
      xor_q        <= '0;
      csum_byte_q  <= '0;
    end else begin
      if (start_ok) begin
        err_q        <= 1'b0;
        csum_phase_q <= 1'b0;
        xor_q        <= '0;
      end else begin
        if (accept) begin
          if (csum_phase_q) begin
            csum_byte_q <= byte_data;
          end else begin
            xor_q <= xor_q ^ byte_data;
          end
        end
        if ((state == WRITE) && last_word) begin
          csum_phase_q <= 1'b1;
        end
        if ((state == CHECK) && (xor_q != csum_byte_q)) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign done       = done_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = word_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven sessions, hand-written corner
// sequences and randomized sessions checked against a word-level memory model.
module tb_imem_loader;

  localparam int ADDR_W = 5;

  logic              clk;
  logic              rstn;
  logic              load_start;
  logic [ADDR_W:0]   load_count;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rstn;
  logic              busy;
  logic              done;
  logic              err;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .RSTn       (rstn),
    .load_start (load_start),
    .load_count (load_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rstn   (cpu_rstn),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cycle_no  = 0;
  int done_total = 0;
  int done_cyc  = 0;
  int viol      = 0;
  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];

  typedef struct {
    string name;
    int    count;
    int    mode;
    int    src;
    int    exp_writes;
    int    exp_lat;
  } vec_t;

  always @(posedge clk) cycle_no <= cycle_no + 1;

  // Observes the write port, done pulses and handshake legality at mid-cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      if (byte_ready) viol++;
    end
`ifndef IMEM_LOADER_CHECKSUM_EN
    else if (busy && !byte_ready) viol++;
`endif
    if (done) begin
      done_total++;
      done_cyc = cycle_no;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] model_word(input logic [7:0] p[$], input int i);
    return {p[4*i], p[4*i+1], p[4*i+2], p[4*i+3]};
  endfunction

  task automatic start_session(input int count);
    @(posedge clk); #1;
    load_start = 1'b1;
    load_count = (ADDR_W+1)'(count);
    @(posedge clk); #1;
    load_start = 1'b0;
    load_count = (ADDR_W+1)'($urandom);
    if (count > 0) begin
      check_output($sformatf("start%0d_busy", count), busy, 1);
      check_output($sformatf("start%0d_cpu_rstn", count), cpu_rstn, 0);
      check_output($sformatf("start%0d_err", count), err, 0);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] bq[$], input int mode,
                                output int first_acc, output int got);
    int  guard;
    bit  tog;
    got = 0;
    first_acc = -1;
    guard = 0;
    tog = 1'b1;
    while (got < bq.size() && guard < 8 * bq.size() + 50) begin
      case (mode)
        0:       byte_valid = 1'b1;
        1:       byte_valid = tog;
        default: byte_valid = ($urandom_range(0, 2) != 0);
      endcase
      tog = !tog;
      byte_data = byte_valid ? bq[got] : 8'($urandom);
      @(negedge clk);
      if (byte_valid && byte_ready) begin
        if (first_acc < 0) first_acc = cycle_no;
        got++;
      end
      @(posedge clk); #1;
      guard++;
    end
    byte_valid = 1'b0;
    check_output("stream_accepted", got, bq.size());
  endtask

  task automatic run_session(input string name, input int count, input logic [7:0] payload[$],
                             input int mode, input int exp_writes, input int exp_lat,
                             input bit bad_csum);
    logic [7:0] sq[$];
    int base_w, base_d, base_v, first_acc, got, guard, lat, n_act, n_cmp;
    bit exp_run;
    exp_run = !bad_csum;
    sq = payload;
`ifdef IMEM_LOADER_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      foreach (payload[i]) x ^= payload[i];
      if (bad_csum) x ^= 8'h01;
      sq.push_back(x);
    end
    lat = (exp_lat >= 0) ? exp_lat + 2 : -1;
`else
    lat = exp_lat;
`endif
    base_w = wr_addr.size();
    base_d = done_total;
    base_v = viol;
    start_session(count);
    apply_stimulus(sq, mode, first_acc, got);
    guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk); #1;
      guard++;
    end
    check_output({name, "_end_busy"}, busy, 0);
    if (lat >= 0) check_output({name, "_latency"}, done_cyc - first_acc, lat);
    @(negedge clk); #1;
    check_output({name, "_done_single"}, done, 0);
    check_output({name, "_done_pulses"}, done_total - base_d, exp_run ? 1 : 0);
    n_act = wr_addr.size() - base_w;
    check_output({name, "_writes"}, n_act, exp_writes);
    n_cmp = (n_act < exp_writes) ? n_act : exp_writes;
    for (int i = 0; i < n_cmp; i++) begin
      check_output($sformatf("%s_addr%0d", name, i), wr_addr[base_w + i], i);
      check_output($sformatf("%s_data%0d", name, i), wr_data[base_w + i], model_word(payload, i));
    end
    check_output({name, "_cpu_rstn"}, cpu_rstn, exp_run);
    check_output({name, "_err"}, err, bad_csum);
    check_output({name, "_handshake"}, viol - base_v, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t        vecs[5];
    logic [31:0] prog[8];
    logic [7:0]  p[$];
    int          nw, base_w, base_d, first_acc, got, cnt;

    prog = '{32'h20030080, 32'h2004000F, 32'hAC040000, 32'h8C050000,
             32'h10830010, 32'h00000000, 32'h00000000, 32'h10A4000C};
    // src: 0 random bytes, 1 reference program, 2 all-zero words
    vecs[0] = '{name: "basic",    count: 8,  mode: 0, src: 1, exp_writes: 8,  exp_lat: 40};
    vecs[1] = '{name: "backpres", count: 8,  mode: 1, src: 1, exp_writes: 8,  exp_lat: -1};
    vecs[2] = '{name: "clamp40",  count: 40, mode: 0, src: 0, exp_writes: 32, exp_lat: 160};
    vecs[3] = '{name: "reload1",  count: 1,  mode: 0, src: 2, exp_writes: 1,  exp_lat: 5};
    vecs[4] = '{name: "gaps3",    count: 3,  mode: 2, src: 0, exp_writes: 3,  exp_lat: -1};

    rstn = 1'b1;
    load_start = 1'b0;
    load_count = '0;
    byte_valid = 1'b0;
    byte_data = '0;
    #3 rstn = 1'b0;
    #1;
    check_output("rst_byte_ready", byte_ready, 0);
    check_output("rst_imem_we", imem_we, 0);
    check_output("rst_imem_addr", imem_addr, 0);
    check_output("rst_imem_wdata", imem_wdata, 0);
    check_output("rst_cpu_rstn", cpu_rstn, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_err", err, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("hold_cpu_rstn", cpu_rstn, 0);
    check_output("hold_byte_ready", byte_ready, 0);

    $display("[TB] count=0 session");
    base_w = wr_addr.size();
    base_d = done_total;
    start_session(0);
    check_output("cnt0_done", done, 1);
    check_output("cnt0_cpu_rstn", cpu_rstn, 1);
    check_output("cnt0_busy", busy, 0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check_output("cnt0_done_after", done, 0);
    check_output("cnt0_pulses", done_total - base_d, 1);
    check_output("cnt0_writes", wr_addr.size() - base_w, 0);

    foreach (vecs[v]) begin
      $display("[TB] table session %s", vecs[v].name);
      nw = (vecs[v].count > 32) ? 32 : vecs[v].count;
      p.delete();
      for (int w = 0; w < nw; w++) begin
        for (int b = 0; b < 4; b++) begin
          case (vecs[v].src)
            1:       p.push_back(prog[w][31 - 8*b -: 8]);
            2:       p.push_back(8'h00);
            default: p.push_back(8'($urandom));
          endcase
        end
      end
      run_session(vecs[v].name, vecs[v].count, p, vecs[v].mode,
                  vecs[v].exp_writes, vecs[v].exp_lat, 1'b0);
    end

    $display("[TB] reset during word 3");
    p.delete();
    for (int w = 0; w < 8; w++)
      for (int b = 0; b < 4; b++) p.push_back(prog[w][31 - 8*b -: 8]);
    base_w = wr_addr.size();
    start_session(8);
    begin
      logic [7:0] part[$];
      part = p[0:13];
      apply_stimulus(part, 0, first_acc, got);
    end
    check_output("midrst_writes_before", wr_addr.size() - base_w, 3);
    #2 rstn = 1'b0;
    #1;
    check_output("midrst_byte_ready", byte_ready, 0);
    check_output("midrst_imem_we", imem_we, 0);
    check_output("midrst_imem_addr", imem_addr, 0);
    check_output("midrst_imem_wdata", imem_wdata, 0);
    check_output("midrst_cpu_rstn", cpu_rstn, 0);
    check_output("midrst_busy", busy, 0);
    check_output("midrst_done", done, 0);
    @(posedge clk); #1 rstn = 1'b1;
    p.delete();
    for (int i = 0; i < 8; i++) p.push_back(8'($urandom));
    run_session("after_rst", 2, p, 0, 2, 10, 1'b0);

    $display("[TB] randomized sessions");
    for (int r = 0; r < 6; r++) begin
      cnt = $urandom_range(1, 10);
      p.delete();
      for (int i = 0; i < 4 * cnt; i++) p.push_back(8'($urandom));
      run_session($sformatf("rand%0d", r), cnt, p, $urandom_range(0, 2), cnt, -1, 1'b0);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    $display("[TB] checksum sessions");
    p.delete();
    for (int i = 0; i < 12; i++) p.push_back(8'($urandom));
    run_session("csum_good", 3, p, 0, 3, 15, 1'b0);
    run_session("csum_bad", 3, p, 0, 3, -1, 1'b1);
    @(negedge clk); #1;
    check_output("csum_bad_stays_hold", cpu_rstn, 0);
    run_session("csum_recover", 3, p, 2, 3, -1, 1'b0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory loader for the single-cycle MIPS core. It receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them into the instruction memory's write port. It holds the CPU in reset until a load session completes, then releases it. It replaces hierarchical memory preloading with a synthesizable path.

## Interface
- ADDR_W, 5, instruction-memory word-address width; capacity 2^ADDR_W words
- clk  in  1  system clock; all state updates on the rising edge
- RSTn  in  1  asynchronous active-low reset
- load_start  in  1  single-cycle request to begin a session; sampled in HOLD and RUN only
- load_count  in  ADDR_W+1  number of words in the session; sampled with load_start
- byte_valid  in  1  byte_data is valid
- byte_data  in  8  stream byte, MSB of each word first
- byte_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address of the write
- imem_wdata  out  32  assembled instruction word
- cpu_rstn  out  1  active-low reset to the CPU core
- busy  out  1  session in progress
- done  out  1  one-cycle pulse on session completion
- err  out  1  checksum failure flag (see Configuration)

## Operation
- States: HOLD, LOAD, WRITE, CHECK (only with the macro), RUN.
- HOLD is the reset state. The CPU is held in reset (cpu_rstn=0) and the loader waits for load_start.
- On load_start in HOLD or RUN:
  - latch the count, clamped to 2^ADDR_W
  - clear the word address and byte counter; clear err
  - enter LOAD
  - a count of 0 goes directly to RUN with a done pulse and no writes
- LOAD:
  - byte_ready=1
  - on byte_valid&&byte_ready, shift byte_data into the word register: word = {word[23:0], byte_data}
  - after the 4th byte of a word, go to WRITE
- WRITE (one cycle):
  - imem_we=1, imem_addr=current word index, imem_wdata=assembled word; byte_ready=0
  - then increment the index
  - if words written == count, go to RUN (or CHECK); otherwise return to LOAD
- RUN:
  - cpu_rstn=1; done pulses for the first cycle of RUN only
  - load_start re-enters LOAD and drops cpu_rstn to 0 from the next cycle
- load_start in LOAD/WRITE/CHECK is ignored; load_count is ignored except when sampled.
- busy=1 in LOAD, WRITE, CHECK.
- Word index never wraps. The clamp guarantees index < 2^ADDR_W at every write.
- Stream bytes beyond the session are not accepted (byte_ready=0 outside LOAD).

## Timing
- Reset values: byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rstn=0, busy=0, done=0, err=0; state=HOLD.
- All outputs are registered or decoded from the state register only; no input-to-output combinational path.
- Minimum cost per word: 4 accepted bytes plus 1 WRITE cycle, i.e. 5 cycles with byte_valid held high.
- imem_we asserts on the cycle after the edge that accepts the 4th byte.
- done and cpu_rstn rise on the same edge, one cycle after the last WRITE (or after CHECK).
- Gaps in byte_valid stall assembly indefinitely; there is no timeout.
- Asserting RSTn low mid-session:
  - immediately return to HOLD and force all outputs to reset values
  - discard the partial word
  - words already written remain in memory

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - after the last word, LOAD accepts one extra byte, the XOR of all payload bytes, then enters CHECK for one cycle
  - on match, go to RUN
  - on mismatch, set err=1 and return to HOLD (CPU stays in reset, no done pulse)
  - err clears on the next load_start
- Not defined: no checksum byte is expected, there is no CHECK state, and err is tied to 0.

## Test plan
- Basic load:
  - stimulus: reset, load_start with count=8, stream 20 03 00 80 | 20 04 00 0F | AC 04 00 00 | 8C 05 00 00 | 10 83 00 10 | 00 00 00 00 | 00 00 00 00 | 10 A4 00 0C with byte_valid continuous
  - required: 8 imem_we pulses, addr 0..7 with data 0x20030080 … 0x10A4000C; done pulse and cpu_rstn=1, 40 cycles after the first accepted byte
- Backpressure:
  - stimulus: same stream, byte_valid toggled 1/0 every cycle
  - required: identical write sequence and data; byte_ready=0 exactly on WRITE cycles
- Count boundaries:
  - stimulus: count=0
  - required: done pulse with no imem_we, and RUN entered one cycle after load_start
  - stimulus: count=40 with ADDR_W=5
  - required: exactly 32 writes, last imem_addr=31
- Reset mid-load:
  - stimulus: RSTn low after 2 bytes of word 3
  - required: all outputs at reset values asynchronously, state HOLD; a new session rewrites from addr 0
- Reload from RUN:
  - stimulus: load_start in RUN with count=1 and bytes 00 00 00 00
  - required: cpu_rstn low from the next cycle, one write to addr 0, then cpu_rstn high again
- Checksum (macro defined):
  - stimulus: correct trailing byte, then a second session with the trailing byte XOR 0x01
  - required: first session reaches RUN; second sets err=1, stays in HOLD with cpu_rstn=0 and no done pulse
